// File: rtl/ysyx_25020047_pkg.sv
// Shared types and constants for the ysyx_25020047 instruction fetch unit.
package ysyx_25020047_pkg;

  typedef enum logic [1:0] {
    IFU_REQ      = 2'd0,
    IFU_WAIT     = 2'd1,
    IFU_HOLD     = 2'd2,
    IFU_WAIT_NPC = 2'd3
  } ifu_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

endpackage

// File: rtl/ysyx_25020047_ifu_perf.sv
// Fetch and stall event counters for the IFU; both wrap at 2^64.
module ysyx_25020047_ifu_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc_i,
  input  logic        stall_inc_i,
  output logic [63:0] perf_fetch_cnt,
  output logic [63:0] perf_stall_cnt
);

  logic [63:0] fetch_cnt_q, fetch_cnt_d;
  logic [63:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + {63'd0, fetch_inc_i};
    stall_cnt_d = stall_cnt_q + {63'd0, stall_inc_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;

endmodule

// File: rtl/ysyx_25020047_ifu.sv
// Multi-cycle instruction fetch unit: REQ -> WAIT -> HOLD -> WAIT_NPC loop.
// Optional performance counters are enabled with the IFU_PERF_CNT_EN macro.
module ysyx_25020047_ifu
  import ysyx_25020047_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] snpc,
  output logic            inst_err,
  input  logic            dnpc_valid,
  input  logic [XLEN-1:0] dnpc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0]     perf_fetch_cnt,
  output logic [63:0]     perf_stall_cnt
`endif
);

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic            err_q, err_d;
  logic            misaligned;

  assign misaligned = (pc_q[1:0] != 2'b00);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    inst_d         = inst_q;
    err_d          = err_q;
    imem_req_valid = 1'b0;
    inst_valid     = 1'b0;
    unique case (state_q)
      IFU_REQ: begin
        // A misaligned PC faults locally and never reaches the memory bus.
        if (misaligned) begin
          inst_d  = '0;
          err_d   = 1'b1;
          state_d = IFU_HOLD;
        end else begin
          imem_req_valid = 1'b1;
          if (imem_req_ready) state_d = IFU_WAIT;
        end
      end
      IFU_WAIT: begin
        if (imem_rsp_valid) begin
          inst_d  = imem_rsp_data;
          err_d   = imem_rsp_err;
          state_d = IFU_HOLD;
        end
      end
      IFU_HOLD: begin
        inst_valid = 1'b1;
        if (inst_ready) state_d = IFU_WAIT_NPC;
      end
      IFU_WAIT_NPC: begin
        if (dnpc_valid) begin
          pc_d    = dnpc;
          state_d = IFU_REQ;
        end
      end
      default: state_d = IFU_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IFU_REQ;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
    end
  end

  assign imem_req_addr = pc_q;
  assign pc            = pc_q;
  assign inst          = inst_q;
  assign inst_err      = err_q;
  assign snpc          = pc_q + {{(XLEN-3){1'b0}}, 3'd4};

  // Stray handshake pulses are dropped by the FSM; flag them in simulation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(dnpc_valid && (state_q != IFU_WAIT_NPC)))
        else $warning("ifu: dnpc_valid ignored outside WAIT_NPC");
      assert (!(imem_rsp_valid && (state_q != IFU_WAIT)))
        else $error("ifu: imem_rsp_valid outside WAIT");
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic fetch_inc, stall_inc;
  assign fetch_inc = (state_q == IFU_HOLD) && inst_ready;
  assign stall_inc = ((state_q == IFU_REQ) && !misaligned && !imem_req_ready) ||
                     ((state_q == IFU_WAIT) && !imem_rsp_valid);

  ysyx_25020047_ifu_perf u_perf (
    .clk            (clk),
    .rst            (rst),
    .fetch_inc_i    (fetch_inc),
    .stall_inc_i    (stall_inc),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_ysyx_25020047_ifu.sv
// Scoreboard bench for the IFU: directed fetches push expected bundles,
// a negedge monitor pops and compares them on every decode handshake.
module tb_ysyx_25020047_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] snpc;
  logic        inst_err;
  logic        dnpc_valid;
  logic [31:0] dnpc;
`ifdef IFU_PERF_CNT_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_stall_cnt;
  logic [63:0] stall0, fetch0;
`endif

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] snpc;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_25020047_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .pc             (pc),
    .snpc           (snpc),
    .inst_err       (inst_err),
    .dnpc_valid     (dnpc_valid),
    .dnpc           (dnpc)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted bundle must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (inst_valid && inst_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_bundle", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_inst", inst, e.inst);
          chk("sb_pc", pc, e.pc);
          chk("sb_snpc", snpc, e.snpc);
          chk("sb_err", inst_err, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic fetch(input int req_dly, input int rsp_dly, input int hold_dly,
                       input logic [31:0] data, input logic err,
                       input logic [31:0] epc, input logic [31:0] esnpc, input bit stray);
    sb.push_back('{data, epc, esnpc, err});
    for (int i = 0; i < req_dly; i++) begin
      chk("req_valid_stall", imem_req_valid, 1);
      chk("req_addr_stall", imem_req_addr, epc);
      @(posedge clk); #1;
    end
    imem_req_ready = 1'b1;
    chk("req_valid", imem_req_valid, 1);
    chk("req_addr", imem_req_addr, epc);
    @(posedge clk); #1;
    imem_req_ready = 1'b0;
    for (int i = 0; i < rsp_dly; i++) begin
      chk("no_valid_in_wait", inst_valid, 0);
      @(posedge clk); #1;
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    imem_rsp_err   = err;
    @(posedge clk); #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    chk("inst_valid_latency", inst_valid, 1);
    for (int i = 0; i < hold_dly; i++) begin
      if (stray && i == 0) begin
        dnpc_valid = 1'b1;
        dnpc       = 32'h1234_5678;
      end
      @(posedge clk); #1;
      dnpc_valid = 1'b0;
      chk("hold_valid", inst_valid, 1);
      chk("hold_inst", inst, data);
      chk("hold_pc", pc, epc);
    end
    inst_ready = 1'b1;
    @(posedge clk); #1;
    inst_ready = 1'b0;
    chk("post_hs_valid", inst_valid, 0);
  endtask

  task automatic misaligned(input logic [31:0] epc, input logic [31:0] esnpc);
    sb.push_back('{32'h0, epc, esnpc, 1'b1});
    chk("mis_no_req", imem_req_valid, 0);
    @(posedge clk); #1;
    chk("mis_valid", inst_valid, 1);
    chk("mis_no_req_hold", imem_req_valid, 0);
    inst_ready = 1'b1;
    @(posedge clk); #1;
    inst_ready = 1'b0;
  endtask

  task automatic next_pc(input logic [31:0] a);
    dnpc_valid = 1'b1;
    dnpc       = a;
    @(posedge clk); #1;
    dnpc_valid = 1'b0;
    dnpc       = '0;
    chk("npc_addr", imem_req_addr, a);
  endtask

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    inst_ready     = 1'b0;
    dnpc_valid     = 1'b0;
    dnpc           = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", imem_req_valid, 1);
    chk("rst_addr", imem_req_addr, 32'h8000_0000);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_err", inst_err, 0);
    rst = 1'b0;

    // zero-wait fetch
    fetch(0, 0, 0, 32'h0010_0093, 1'b0, 32'h8000_0000, 32'h8000_0004, 1'b0);
    next_pc(32'h8000_0004);

    // delayed req_ready and response
`ifdef IFU_PERF_CNT_EN
    stall0 = perf_stall_cnt;
    fetch0 = perf_fetch_cnt;
`endif
    fetch(3, 4, 0, 32'h0020_8113, 1'b0, 32'h8000_0004, 32'h8000_0008, 1'b0);
`ifdef IFU_PERF_CNT_EN
    chk("perf_stall_delta", perf_stall_cnt - stall0, 64'd7);
    chk("perf_fetch_delta", perf_fetch_cnt - fetch0, 64'd1);
`endif
    next_pc(32'h8000_0008);

    // decode backpressure
    fetch(0, 0, 5, 32'h0000_0517, 1'b0, 32'h8000_0008, 32'h8000_000C, 1'b0);
    next_pc(32'h8000_0010);
    chk("bp_req_valid", imem_req_valid, 1);

    // faulting response then clean response
    fetch(1, 1, 0, 32'hDEAD_BEEF, 1'b1, 32'h8000_0010, 32'h8000_0014, 1'b0);
    next_pc(32'h8000_0014);
    fetch(0, 0, 0, 32'h0010_0073, 1'b0, 32'h8000_0014, 32'h8000_0018, 1'b0);

    // misaligned next PC
    next_pc(32'h8000_0006);
    misaligned(32'h8000_0006, 32'h8000_000A);

    // top-of-space PC wraps snpc; stray dnpc in HOLD is ignored
    next_pc(32'hFFFF_FFFC);
    fetch(0, 2, 2, 32'h0000_0013, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 1'b1);
    next_pc(32'h8000_0020);

    // reset while waiting for the response
    imem_req_ready = 1'b1;
    @(posedge clk); #1;
    imem_req_ready = 1'b0;
    chk("wait_no_valid", inst_valid, 0);
    chk("wait_no_req", imem_req_valid, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_req_valid", imem_req_valid, 1);
    chk("midrst_addr", imem_req_addr, 32'h8000_0000);
    chk("midrst_inst_valid", inst_valid, 0);

    fetch(0, 0, 0, 32'h1234_5678, 1'b0, 32'h8000_0000, 32'h8000_0004, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
